// File: rtl/sram_arb_ctrl_if.sv
// Client request/ack ports plus SRAM strobe and tristate data-path signals of sram_arb_ctrl.
interface sram_arb_ctrl_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
) ();
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              we1;
  logic [1:0]        be1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;
  logic              SRAM_WE_N;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;
  logic [DATA_W-1:0] Data_write;
  logic              tri_oe;
  logic [DATA_W-1:0] Data_read;

  modport slave (
    input  req0, addr0, req1, addr1, we1, be1, wdata1, Data_read,
    output ack0, rdata0, ack1, rdata1,
           SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
           Data_write, tri_oe
  );

  modport master (
    output req0, addr0, req1, addr1, we1, be1, wdata1, Data_read,
    input  ack0, rdata0, ack1, rdata1,
           SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
           Data_write, tri_oe
  );
endinterface

// File: rtl/sram_arb_ctrl.sv
// Two-client async SRAM controller: port 0 (video reads) vs port 1 (game read/write),
// streak-limited priority for port 0, registered strobes, one idle turnaround cycle per access.
module sram_arb_ctrl #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MAX_STREAK = 3
) (
  input  logic           Clk,
  input  logic           Reset,
  sram_arb_ctrl_if.slave bus
);

  localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  typedef enum logic [2:0] {
    IDLE,
    RD_SETUP,
    RD_WAIT,
    RD_DONE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  state_t              state, state_d;
  logic                port_q, port_d;
  logic [1:0]          be_q, be_d;
  logic [STREAK_W-1:0] streak, streak_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q, tri_oe_q;
  logic                ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, tri_oe_d;
  logic                ack0_q, ack1_q, ack0_d, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic                grant1;

  // Next state, arbitration and the output values of the state being entered
  always_comb begin
    state_d  = state;
    port_d   = port_q;
    be_d     = be_q;
    streak_d = streak;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    grant1   = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant1 = bus.req1 && (!bus.req0 || (streak == STREAK_MAX));
          port_d = grant1;
          if (grant1) begin
            addr_d   = bus.addr1;
            be_d     = bus.be1;
            streak_d = '0;
            if (bus.we1) begin
              wdata_d = bus.wdata1;
              state_d = WR_SETUP;
            end else begin
              state_d = RD_SETUP;
            end
          end else begin
            addr_d = bus.addr0;
            be_d   = 2'b11;
            if (!bus.req1)
              streak_d = '0;
            else if (streak != STREAK_MAX)
              streak_d = streak + 1'b1;
            state_d = RD_SETUP;
          end
        end
      end
      RD_SETUP: state_d = RD_WAIT;
      RD_WAIT:  state_d = RD_DONE;
      RD_DONE:  state_d = IDLE;
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: state_d = WR_HOLD;
      WR_HOLD:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    tri_oe_d = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;

    unique case (state_d)
      RD_SETUP, RD_WAIT, RD_DONE: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
        ack0_d = (state_d == RD_DONE) && !port_d;
        ack1_d = (state_d == RD_DONE) && port_d;
      end
      WR_SETUP, WR_PULSE, WR_HOLD: begin
        ce_n_d   = 1'b0;
        ub_n_d   = ~be_d[1];
        lb_n_d   = ~be_d[0];
        tri_oe_d = (state_d != WR_SETUP);
        // An all-zero byte mask still completes the handshake but never pulses WE_N
        we_n_d   = !((state_d == WR_PULSE) && (be_d != 2'b00));
        ack1_d   = (state_d == WR_HOLD);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      port_q   <= 1'b0;
      be_q     <= 2'b00;
      streak   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      tri_oe_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state    <= state_d;
      port_q   <= port_d;
      be_q     <= be_d;
      streak   <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      ub_n_q   <= ub_n_d;
      lb_n_q   <= lb_n_d;
      tri_oe_q <= tri_oe_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      if (state == RD_DONE) begin
        if (port_q)
          rdata1_q <= bus.Data_read;
        else
          rdata0_q <= bus.Data_read;
      end
    end
  end

  // Data_read becomes valid only on the edge entering RD_DONE, so it is forwarded during the ack cycle
  assign bus.rdata0 = ((state == RD_DONE) && !port_q) ? bus.Data_read : rdata0_q;
  assign bus.rdata1 = ((state == RD_DONE) && port_q)  ? bus.Data_read : rdata1_q;

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.SRAM_ADDR  = addr_q;
  assign bus.SRAM_CE_N  = ce_n_q;
  assign bus.SRAM_OE_N  = oe_n_q;
  assign bus.SRAM_WE_N  = we_n_q;
  assign bus.SRAM_UB_N  = ub_n_q;
  assign bus.SRAM_LB_N  = lb_n_q;
  assign bus.Data_write = wdata_q;
  assign bus.tri_oe     = tri_oe_q;

endmodule
